// File: rtl/mux4to1_4b_pkg.sv
// Shared constants for the mux4to1_4b operand-steering primitive.
// Select encodings map directly onto the operand index I0..I3.
package mux4to1_4b_pkg;

    localparam logic [1:0] SEL_I0 = 2'd0;
    localparam logic [1:0] SEL_I1 = 2'd1;
    localparam logic [1:0] SEL_I2 = 2'd2;
    localparam logic [1:0] SEL_I3 = 2'd3;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/mux4to1_4b_comb.sv
// Pure combinational WIDTH-bit 4:1 selector (module mux4to1_comb).
// Every select value is legal, so the case statement is fully covered.
module mux4to1_comb
    import mux4to1_4b_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (sel)
            SEL_I0: y = d0;
            SEL_I1: y = d1;
            SEL_I2: y = d2;
            SEL_I3: y = d3;
        endcase
    end

endmodule

// File: rtl/mux4to1_4b.sv
// 4:1 selector with a combinational output and an enable-loaded, reset-defined copy.
// Define MUX4TO1_4B_PARITY_EN to add par_q, the even parity of the registered word.
module mux4to1_4b
    import mux4to1_4b_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       s,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic [WIDTH-1:0] I2,
    input  logic [WIDTH-1:0] I3,
    input  logic             en,
    output logic [WIDTH-1:0] o,
    output logic [WIDTH-1:0] o_q,
`ifdef MUX4TO1_4B_PARITY_EN
    output logic             par_q,
`endif
    output logic [1:0]       sel_q
);

    logic [WIDTH-1:0] selected;

    mux4to1_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .sel (s),
        .d0  (I0),
        .d1  (I1),
        .d2  (I2),
        .d3  (I3),
        .y   (selected)
    );

    assign o = selected;

    // Reset is checked first so it wins over a simultaneous enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q   <= '0;
            sel_q <= SEL_I0;
`ifdef MUX4TO1_4B_PARITY_EN
            par_q <= 1'b0;
`endif
        end else if (en) begin
            o_q   <= selected;
            sel_q <= s;
`ifdef MUX4TO1_4B_PARITY_EN
            par_q <= ^selected;
`endif
        end
    end

endmodule

// File: tb/tb_mux4to1_4b.sv
// Self-checking bench for mux4to1_4b: vector table, directed corner sequences, random vs. model.
// Works in both builds; parity checks are added when MUX4TO1_4B_PARITY_EN is defined.
module tb_mux4to1_4b;
    import mux4to1_4b_pkg::*;

    localparam int WIDTH = DEFAULT_WIDTH;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [1:0]       s;
    logic [WIDTH-1:0] i0, i1, i2, i3;
    logic [WIDTH-1:0] o, o_q;
    logic [1:0]       sel_q;
`ifdef MUX4TO1_4B_PARITY_EN
    logic             par_q;
`endif

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] model_q;
    logic [1:0]       model_sel;

    typedef struct {
        logic [1:0]       s;
        logic [WIDTH-1:0] i0, i1, i2, i3;
        logic [WIDTH-1:0] exp_o;
    } vec_t;

    vec_t vecs[8];

    mux4to1_4b #(
        .WIDTH (WIDTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (s),
        .I0    (i0),
        .I1    (i1),
        .I2    (i2),
        .I3    (i3),
        .en    (en),
        .o     (o),
        .o_q   (o_q),
`ifdef MUX4TO1_4B_PARITY_EN
        .par_q (par_q),
`endif
        .sel_q (sel_q)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] pick(input logic [1:0] sv, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] c,
                                              input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] arr[4];
        arr = '{a, b, c, d};
        return arr[sv];
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_regs(input string tag, input logic [WIDTH-1:0] exp_q, input logic [1:0] exp_sel);
        check_output({tag, " o_q"}, o_q, exp_q);
        check_output({tag, " sel_q"}, sel_q, exp_sel);
`ifdef MUX4TO1_4B_PARITY_EN
        check_output({tag, " par_q"}, par_q, $countones(exp_q) % 2);
`endif
    endtask

    task automatic check_comb(input string tag);
        check_output({tag, " o"}, o, pick(s, i0, i1, i2, i3));
    endtask

    task automatic apply_stimulus(input logic [1:0] sv, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d, input logic e);
        @(negedge clk);
        s  = sv;
        i0 = a;
        i1 = b;
        i2 = c;
        i3 = d;
        en = e;
    endtask

    task automatic clock_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        s     = 2'd0;
        {i0, i1, i2, i3} = '0;

        vecs[0] = '{SEL_I0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
        vecs[1] = '{SEL_I1, 4'd0, 4'd1, 4'd2, 4'd3, 4'd1};
        vecs[2] = '{SEL_I2, 4'd0, 4'd1, 4'd2, 4'd3, 4'd2};
        vecs[3] = '{SEL_I3, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3};
        vecs[4] = '{SEL_I3, 4'hF, 4'h0, 4'hA, 4'h5, 4'h5};
        vecs[5] = '{SEL_I0, 4'hC, 4'h3, 4'h9, 4'h6, 4'hC};
        vecs[6] = '{SEL_I2, 4'h1, 4'h2, 4'hE, 4'h8, 4'hE};
        vecs[7] = '{SEL_I1, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF};

        #12;
        check_regs("reset", '0, 2'd0);

        // Unclocked sweep, held in reset to show o ignores rst_n.
        for (int k = 0; k < 8; k++) begin
            apply_stimulus(vecs[k].s, vecs[k].i0, vecs[k].i1, vecs[k].i2, vecs[k].i3, 1'b0);
            #1;
            check_output($sformatf("vec%0d o", k), o, vecs[k].exp_o);
            #49;
        end
        check_regs("reset hold", '0, 2'd0);

        @(negedge clk);
        rst_n = 1'b1;

        apply_stimulus(SEL_I2, 4'h0, 4'h0, 4'hA, 4'h0, 1'b1);
        clock_edge();
        check_regs("load A", 4'hA, 2'd2);

        apply_stimulus(SEL_I0, 4'h5, 4'h1, 4'h2, 4'h3, 1'b1);
        clock_edge();
        check_regs("load 5", 4'h5, 2'd0);
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'b0);
            #1;
            check_comb("hold");
            clock_edge();
            check_regs("hold", 4'h5, 2'd0);
        end

        apply_stimulus(SEL_I3, 4'h1, 4'h2, 4'h4, 4'hF, 1'b1);
        clock_edge();
        check_regs("load F", 4'hF, 2'd3);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_regs("async reset", '0, 2'd0);
        check_comb("async reset");

        apply_stimulus(SEL_I3, 4'h1, 4'h2, 4'h4, 4'h7, 1'b1);
        clock_edge();
        check_regs("reset priority", '0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clock_edge();
        check_regs("after release", 4'h7, 2'd3);

        apply_stimulus(SEL_I1, 4'h0, 4'b0111, 4'h0, 4'h0, 1'b1);
        clock_edge();
        check_regs("odd ones", 4'b0111, 2'd1);
        apply_stimulus(SEL_I0, 4'b0011, 4'h0, 4'h0, 4'h0, 1'b1);
        clock_edge();
        check_regs("even ones", 4'b0011, 2'd0);

        model_q   = '0;
        model_sel = '0;
        for (int k = 0; k < 300; k++) begin
            apply_stimulus(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                           (k == 0) ? 1'b1 : ($urandom_range(0, 3) != 0));
            #1;
            check_comb("random");
            @(posedge clk);
            if (en) begin
                model_q   = pick(s, i0, i1, i2, i3);
                model_sel = s;
            end
            #1;
            check_regs("random", model_q, model_sel);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux4to1_4b.md
# mux4to1_4b

Four-input, 4-bit-wide selector with a combinational data path and a registered copy of the selected word. It picks one of four operand buses (I0..I3) under a 2-bit select. It serves as the generic operand-steering primitive in datapath blocks. The combinational output is for same-cycle consumers; the registered output is for consumers that need a clean, reset-defined value.

## Interface
Parameters:
- WIDTH, 4, bit width of each data input and of o / o_q.

Ports:
- clk  in  1  single clock; all registers update on rising edge.
- rst_n  in  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk (external synchronizer).
- s  in  2  select: 0→I0, 1→I1, 2→I2, 3→I3.
- I0  in  WIDTH  data input 0.
- I1  in  WIDTH  data input 1.
- I2  in  WIDTH  data input 2.
- I3  in  WIDTH  data input 3.
- en  in  1  load enable for the output registers.
- o  out  WIDTH  combinational selected word.
- o_q  out  WIDTH  registered selected word.
- sel_q  out  2  select value captured with o_q.
- par_q  out  1  even parity of o_q; present only with MUX4TO1_4B_PARITY_EN.

## Operation
- o = I[s], purely combinational, with no dependency on clk, rst_n or en.
- Every value of s is legal; there is no default or invalid case.
- When en = 1 at a rising clk edge: o_q ← I[s] and sel_q ← s.
- When en = 0: o_q and sel_q hold their values.
- A change on s or on any Ix propagates to o in the same delta. It reaches o_q only at the next enabled edge.
- The data path has no arithmetic; width is preserved exactly, with no extension or truncation.

## Timing
- o: zero-cycle latency; combinational path from s/Ix to o.
- o_q, sel_q: one-cycle latency from an enabled edge.
- Reset values: o_q = 0, sel_q = 0, par_q = 0; o is unaffected by reset and keeps following I[s].
- Assertion of rst_n = 0 mid-operation clears the registers asynchronously, without waiting for clk.
- When rst_n and en are active in the same cycle, reset wins.
- The first load happens at the first rising edge with rst_n = 1 and en = 1.
- No handshake, no state machine.

## Configuration
- MUX4TO1_4B_PARITY_EN defined: adds the par_q port. par_q ← ^I[s] (XOR reduction, i.e. 1 when odd ones-count) loaded under the same en and reset rules as o_q, so par_q always describes the current o_q.
- Macro undefined: the par_q port and its register do not exist; all other behaviour is identical.

## Structure
- Package mux4to1_4b_pkg holds:
  - select constants SEL_I0 = 2'd0, SEL_I1 = 2'd1, SEL_I2 = 2'd2, SEL_I3 = 2'd3;
  - DEFAULT_WIDTH = 4.
- One natural sub-module: mux4to1_comb, the pure combinational WIDTH-bit 4:1 selector driving o.
- The top level adds the enable/reset register stage and the optional parity.

## Test plan
- Select sweep, unclocked: I0=0, I1=1, I2=2, I3=3; s steps 0,1,2,3 at 50 ns intervals → o = 0,1,2,3 respectively, each valid within the same step.
- Registered load: rst_n=1, en=1, I2=4'hA, s=2 → after one rising edge o_q = 4'hA and sel_q = 2; with par enabled, par_q = 0.
- Hold: load o_q = 4'h5, then drop en=0 and change s and all Ix → o follows the new inputs each cycle while o_q stays 4'h5.
- Asynchronous reset mid-run: o_q = 4'hF, pull rst_n low between clock edges → o_q = 0 and sel_q = 0 immediately; o still equals I[s].
- Reset priority: rst_n=0 and en=1 across an edge with I3=4'h7, s=3 → o_q remains 0; it becomes 4'h7 at the first edge after release.
- Parity build (macro defined): load I1 = 4'b0111 with s=1 → par_q = 1; load I0 = 4'b0011 with s=0 → par_q = 0.
